// File: rtl/ula_arbiter_pkg.sv
// Shared types and constants for the two-requester ULA arbiter.
package ula_arbiter_pkg;

  localparam int unsigned OPW              = 29;
  localparam int unsigned NREQ             = 2;
  localparam int unsigned TIMEOUT_DEF      = 255;
  localparam int unsigned START_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Operand bundle presented to the ULA for one operation.
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic           sign_a;
    logic           sign_b;
    logic           op;
  } operand_t;

  // One-hot requester vector for a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/ula_arbiter_if.sv
// Requester-side and ULA-side signals of the arbiter.
interface ula_arbiter_if;
  import ula_arbiter_pkg::*;

  logic [NREQ-1:0] req;
  logic [OPW-1:0]  a0, b0, a1, b1;
  logic [NREQ-1:0] sign_a, sign_b, op;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] rsp_valid;
  logic [OPW-1:0]  rsp_c;
  logic            rsp_sign, rsp_err;
  logic            busy;
  logic [OPW-1:0]  ula_a, ula_b;
  logic            ula_sign_a, ula_sign_b, ula_op, ula_start;
  logic [OPW-1:0]  ula_c;
  logic            ula_sign_c, ula_done;

  // Arbiter view.
  modport slave (
    input  req, a0, b0, a1, b1, sign_a, sign_b, op, ula_c, ula_sign_c, ula_done,
    output ack, rsp_valid, rsp_c, rsp_sign, rsp_err, busy,
           ula_a, ula_b, ula_sign_a, ula_sign_b, ula_op, ula_start
  );

  // Environment view: requesters plus the ULA.
  modport master (
    output req, a0, b0, a1, b1, sign_a, sign_b, op, ula_c, ula_sign_c, ula_done,
    input  ack, rsp_valid, rsp_c, rsp_sign, rsp_err, busy,
           ula_a, ula_b, ula_sign_a, ula_sign_b, ula_op, ula_start
  );

endinterface

// File: rtl/ula_arbiter_rr_arbiter2.sv
// Two-input round-robin pick against a last-granted pointer.
module rr_arbiter2
  import ula_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic            any_c,
  output logic            grant_c
);

  // Contention goes to the requester not granted last; otherwise the lone requester wins.
  always_comb begin
    any_c   = |req;
    grant_c = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/ula_arbiter.sv
// Shares one external ULA between two requesters, with start pulse, done guard and timeout.
module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned START_CYCLES = START_CYCLES_DEF
) (
  input logic          clk,
  input logic          reset,
  ula_arbiter_if.slave bus
);

  localparam int unsigned CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             owner, owner_d;
  logic             last, last_d;
  logic             seen_low, seen_low_d;
  operand_t         opnd, opnd_d, req_opnd_c;
  logic [NREQ-1:0]  ack_r, ack_d;
  logic [NREQ-1:0]  rsp_valid_r, rsp_valid_d;
  logic [OPW-1:0]   rsp_c_r, rsp_c_d;
  logic             rsp_sign_r, rsp_sign_d;
  logic             rsp_err_r, rsp_err_d;
  logic             busy_r, busy_d;
  logic             start_r, start_d;
  logic             any_c, grant_c, done_ok_c, tmo_c, start_last_c;

  rr_arbiter2 u_rr (
    .req     (bus.req),
    .last    (last),
    .any_c   (any_c),
    .grant_c (grant_c)
  );

  assign req_opnd_c = grant_c
    ? {bus.a1, bus.b1, bus.sign_a[1], bus.sign_b[1], bus.op[1]}
    : {bus.a0, bus.b0, bus.sign_a[0], bus.sign_b[0], bus.op[0]};

  // A done that was already high at START entry is ignored until it has been seen low.
  assign done_ok_c    = bus.ula_done & seen_low;
  assign tmo_c        = (cnt == CNT_W'(TIMEOUT - 1));
  assign start_last_c = (cnt == CNT_W'(START_CYCLES - 1));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      last        <= 1'b1;
      seen_low    <= 1'b0;
      opnd        <= '0;
      ack_r       <= '0;
      rsp_valid_r <= '0;
      rsp_c_r     <= '0;
      rsp_sign_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      start_r     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      owner       <= owner_d;
      last        <= last_d;
      seen_low    <= seen_low_d;
      opnd        <= opnd_d;
      ack_r       <= ack_d;
      rsp_valid_r <= rsp_valid_d;
      rsp_c_r     <= rsp_c_d;
      rsp_sign_r  <= rsp_sign_d;
      rsp_err_r   <= rsp_err_d;
      busy_r      <= busy_d;
      start_r     <= start_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:  if (any_c) state_d = S_START;
      S_START: if (start_last_c) state_d = S_WAIT;
      S_WAIT:  if (done_ok_c || tmo_c) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of counter, bookkeeping and outputs.
  always_comb begin
    cnt_d       = cnt;
    owner_d     = owner;
    last_d      = last;
    seen_low_d  = seen_low;
    opnd_d      = opnd;
    ack_d       = '0;
    rsp_valid_d = '0;
    rsp_c_d     = rsp_c_r;
    rsp_sign_d  = rsp_sign_r;
    rsp_err_d   = rsp_err_r;
    busy_d      = (state_d != S_IDLE);
    start_d     = (state_d == S_START);
    case (state)
      S_IDLE: begin
        if (any_c) begin
          owner_d    = grant_c;
          opnd_d     = req_opnd_c;
          ack_d      = onehot(grant_c);
          cnt_d      = '0;
          seen_low_d = 1'b0;
        end
      end
      S_START: begin
        seen_low_d = seen_low | ~bus.ula_done;
        cnt_d      = start_last_c ? '0 : cnt + CNT_W'(1);
      end
      S_WAIT: begin
        seen_low_d = seen_low | ~bus.ula_done;
        cnt_d      = cnt + CNT_W'(1);
        if (done_ok_c) begin
          rsp_c_d     = bus.ula_c;
          rsp_sign_d  = bus.ula_sign_c;
          rsp_err_d   = 1'b0;
          rsp_valid_d = onehot(owner);
        end else if (tmo_c) begin
          rsp_c_d     = '0;
          rsp_sign_d  = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = onehot(owner);
        end
      end
      S_RESP: last_d = owner;
      default: ;
    endcase
  end

  assign bus.ack        = ack_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_c      = rsp_c_r;
  assign bus.rsp_sign   = rsp_sign_r;
  assign bus.rsp_err    = rsp_err_r;
  assign bus.busy       = busy_r;
  assign bus.ula_start  = start_r;
  assign bus.ula_a      = opnd.a;
  assign bus.ula_b      = opnd.b;
  assign bus.ula_sign_a = opnd.sign_a;
  assign bus.ula_sign_b = opnd.sign_b;
  assign bus.ula_op     = opnd.op;

endmodule
